// File: rtl/demux_clog2_pkg.sv
// Constant ceil(log2(n)) helper shared by parametrised blocks.
// Guarded so a later block may include this file without redefining the package.
`ifndef DEMUX_CLOG2_PKG_SV
`define DEMUX_CLOG2_PKG_SV

package demux_clog2_pkg;

  // Counts the powers of two strictly below n; the result is ceil(log2(n)) for n >= 1.
  function automatic int unsigned clog2_const(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/demux_stream_pkg.sv
// Shared types and helpers for the stream demultiplexer.
package demux_stream_pkg;

  localparam int unsigned DROP_W = 8;

  typedef logic [DROP_W-1:0] drop_cnt_t;

  localparam drop_cnt_t DROP_MAX = '1;

  // Saturating increment so the drop counter never wraps.
  function automatic drop_cnt_t drop_sat_inc(input drop_cnt_t c);
    return (c == DROP_MAX) ? c : c + DROP_W'(1);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: a valid bit plus data register, loadable while draining.
module demux_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;

  // A load wins over a drain so drain-and-refill keeps the slot full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign q     = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/demux_stream.sv
// Ready/valid stream demultiplexer: unicast by select, broadcast to all channels,
// and counted discard of words addressed to a non-existent channel.
module demux_stream
  import demux_stream_pkg::*;
  import demux_clog2_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned WAYS  = 4,
  localparam int unsigned SEL_W = clog2_const(WAYS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [SEL_W-1:0]      select,
  input  logic                  broadcast,
  output logic [WAYS*WIDTH-1:0] out,
  output logic [WAYS-1:0]       outValid,
  input  logic [WAYS-1:0]       outReady,
  output logic [7:0]            dropCount
);

  localparam logic [SEL_W:0] WAYS_L = (SEL_W+1)'(WAYS);

  logic [WAYS-1:0] slot_valid;
  logic [WAYS-1:0] slot_free_c;
  logic [WAYS-1:0] slot_drain_c;
  logic [WAYS-1:0] slot_load_c;
  logic            sel_legal_c;
  logic            in_ready_c;
  logic            accept_c;
  logic            drop_c;
  drop_cnt_t       drop_cnt_d, drop_cnt_q;

  // Readiness never looks at inValid; a slot is free when empty or draining this cycle.
  always_comb begin
    sel_legal_c  = ({1'b0, select} < WAYS_L);
    slot_drain_c = slot_valid & outReady;
    slot_free_c  = ~slot_valid | outReady;
    in_ready_c   = 1'b0;
    if (reset) begin
      in_ready_c = 1'b0;
    end else if (broadcast) begin
      in_ready_c = &slot_free_c;
    end else if (!sel_legal_c) begin
      in_ready_c = 1'b1;
    end else begin
      for (int unsigned k = 0; k < WAYS; k++) begin
        if (select == SEL_W'(k)) in_ready_c = slot_free_c[k];
      end
    end

    accept_c    = inValid & in_ready_c;
    slot_load_c = '0;
    if (accept_c) begin
      if (broadcast) begin
        slot_load_c = '1;
      end else begin
        for (int unsigned k = 0; k < WAYS; k++) begin
          if (sel_legal_c && (select == SEL_W'(k))) slot_load_c[k] = 1'b1;
        end
      end
    end

    drop_c     = accept_c & ~broadcast & ~sel_legal_c;
    drop_cnt_d = drop_c ? drop_sat_inc(drop_cnt_q) : drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  for (genvar k = 0; k < WAYS; k++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk   (clk),
      .reset (reset),
      .load  (slot_load_c[k]),
      .drain (slot_drain_c[k]),
      .d     (in),
      .q     (out[k*WIDTH +: WIDTH]),
      .valid (slot_valid[k])
    );
  end

  assign inReady   = in_ready_c;
  assign outValid  = slot_valid;
  assign dropCount = drop_cnt_q;

endmodule
